// File: rtl/zrb_uart_pkg.sv
// Shared UART types and constants: arbiter FSM state, byte width, default stall timeout.
package zrb_uart_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int ZRB_UART_DATA_WIDTH     = 8;
    localparam int ZRB_TX_ARB_TIMEOUT_DFLT = 4096;

endpackage

// File: rtl/zrb_uart_tx_arbiter_if.sv
// Requester-side and FIFO-side signals of the UART TX arbiter.
// master = environment (requesters + FIFO), slave = arbiter.
interface zrb_uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8
) ();
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic [NUM_REQ-1:0]            grant;
    logic                          busy;
    logic                          abort;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr, fifo_data, grant, busy, abort
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr, fifo_data, grant, busy, abort
    );
endinterface

// File: rtl/zrb_rr_select.sv
// Combinational rotate-priority picker: first set req bit searching upward from last+1 with wrap.
module zrb_rr_select #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  sel,
    output logic [IW-1:0] idx,
    output logic          any
);
    int j;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        sel = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int off = 1; off <= N; off++) begin
            j = int'(last) + off;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                sel[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/zrb_uart_tx_arbiter.sv
// Frame-granular round-robin arbiter in front of the shared UART TX FIFO write port.
// Optional stall-timeout abort enabled by defining ZRB_TX_ARB_TIMEOUT_EN.
module zrb_uart_tx_arbiter
    import zrb_uart_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = ZRB_UART_DATA_WIDTH,
    parameter int TIMEOUT    = ZRB_TX_ARB_TIMEOUT_DFLT
) (
    input  logic                  clk,
    input  logic                  reset,
    zrb_uart_tx_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("zrb_uart_tx_arbiter: TIMEOUT must be >= 2");
    end

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   g_q, g_d;
    logic [IDX_W-1:0]   last_g_q, last_g_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               abort_q, abort_d;

    logic [NUM_REQ-1:0] pick_sel;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               locked, g_valid, accept, timed_out;

    zrb_rr_select #(.N(NUM_REQ), .IW(IDX_W)) u_sel (
        .req  (bus.req_valid),
        .last (last_g_q),
        .sel  (pick_sel),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign locked  = (state_q == LOCKED);
    assign g_valid = bus.req_valid[g_q];
    assign accept  = locked & g_valid & ~bus.fifo_full;

`ifdef ZRB_TX_ARB_TIMEOUT_EN
    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] stall_q, stall_d;

    // A full FIFO with valid held is back-pressure, not a stall: the count only moves without valid.
    assign timed_out = locked & ~g_valid & (stall_q == CNT_MAX);

    always_comb begin
        stall_d = stall_q;
        if (!locked || accept)        stall_d = '0;
        else if (!g_valid && !timed_out) stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end
`else
    assign timed_out = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q  <= IDLE;
            g_q      <= '0;
            last_g_q <= IDX_W'(NUM_REQ - 1);
            grant_q  <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            last_g_q <= last_g_d;
            grant_q  <= grant_d;
            abort_q  <= abort_d;
        end
    end

    // Next-state logic; acceptance and timeout are exclusive since timeout needs valid low.
    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        last_g_d = last_g_q;
        grant_d  = grant_q;
        abort_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = LOCKED;
                    g_d     = pick_idx;
                    grant_d = pick_sel;
                end
            end
            LOCKED: begin
                if ((accept && bus.req_last[g_q]) || timed_out) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    last_g_d = g_q;
                    abort_d  = timed_out;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: write path is combinational from the registered grant index.
    always_comb begin
        bus.req_ready = '0;
        bus.fifo_wr   = 1'b0;
        bus.fifo_data = '0;
        if (locked) begin
            bus.req_ready = grant_q & {NUM_REQ{~bus.fifo_full}};
            bus.fifo_wr   = accept;
            bus.fifo_data = bus.req_data[int'(g_q)*DATA_WIDTH +: DATA_WIDTH];
        end
        bus.grant = grant_q;
        bus.busy  = locked;
        bus.abort = abort_q;
    end
endmodule
